path_sequencer: RTL
===================

PATH_SEQUENCER -- requirements
Module: path_sequencer

Interface
REQ-001 The block SHALL expose the following ports, one per line as name, direction, width, meaning:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a new path; honoured only in IDLE.
REQ-005 pt_valid  input  1  waypoint present on pt_x/pt_y/pt_last.
REQ-006 pt_x, pt_y  input  4 each  waypoint coordinates, unsigned 0..15.
REQ-007 pt_last  input  1  marks the final waypoint of the path.
REQ-008 pt_ready  output  1  block accepts a waypoint this cycle.
REQ-009 seg_valid  output  1  one-cycle pulse; segment result outputs are valid.
REQ-010 seg_dist  output  4  segment Manhattan distance, modulo 16.
REQ-011 seg_wrap  output  1  true segment distance exceeded 15.
REQ-012 seg_dir  output  3  segment direction: N=0, NE=1, E=2, SE=3, S=4, SW=5, W=6, NW=7.
REQ-013 total  output  8  accumulated true path length, saturating.
REQ-014 seg_count  output  4  segments completed, saturating at 15.
REQ-015 turns  output  4  direction changes, saturating at 15.
REQ-016 busy  output  1  high in FIRST and RUN.
REQ-017 done  output  1  one-cycle pulse at path completion.

Function
REQ-018 The block SHALL instantiate the team's distance/direction unit, driving A/B with the previous waypoint x/y and C/D with the newly accepted x/y; it SHALL use only that unit for seg_dist and seg_dir.
REQ-019 The true segment distance SHALL be computed as a 5-bit sum of |dx|+|dy| (range 0..30); seg_wrap = true sum > 15.
REQ-020 FSM states SHALL be IDLE, FIRST, RUN.
REQ-021 IDLE: pt_ready=0; start=1 clears total, seg_count, turns, previous-direction-valid flag, and moves to FIRST next cycle.
REQ-022 FIRST: pt_ready=1; accepted point (pt_valid & pt_ready) is stored as previous point; no segment emitted; pt_last=1 -> done pulses next cycle, go IDLE; else go RUN.
REQ-023 RUN: pt_ready=1; each accepted point produces one segment; previous point updated to the new point in the same edge.
REQ-024 Segment latency SHALL be exactly 1 cycle: seg_valid, seg_dist, seg_wrap, seg_dir and updated total/seg_count/turns all appear the cycle after acceptance.
REQ-025 seg_dist/seg_wrap/seg_dir SHALL hold their last values when seg_valid=0.
REQ-026 total SHALL add the true 5-bit distance and saturate at 255; no wrap.
REQ-027 turns SHALL increment when a non-zero-length segment's direction differs from the last non-zero-length segment's direction; first non-zero segment never counts.
REQ-028 Zero-length segment (repeated point): seg_valid pulses, seg_dist=0, seg_dir=0, seg_count increments, turns and stored previous direction unchanged.
REQ-029 Accepted pt_last in RUN: final segment and done pulse SHALL occur in the same cycle; state returns to IDLE.
REQ-030 start while busy SHALL be ignored; pt_valid in IDLE SHALL be ignored (pt_ready=0).
REQ-031 There is no output back-pressure; one point accepted per cycle maximum in FIRST/RUN.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and clear all outputs to 0 (pt_ready, seg_valid, seg_dist, seg_wrap, seg_dir, total, seg_count, turns, busy, done), including mid-path; no pending segment or done survives reset.
REQ-033 After rst_n deasserts, the block SHALL require a new start before accepting points.

Verification
REQ-034 start; points (0,0),(3,0),(3,4),(1,4 last) on consecutive cycles -> segs (3,E=2),(4,N=0),(2,W=6); done with last seg; total=9, seg_count=3, turns=2.
REQ-035 start; (0,0),(15,15 last) -> seg_dist=14, seg_wrap=1, seg_dir=1, total=30, turns=0.
REQ-036 start; alternate (0,0)/(15,15) for 11 points -> 10 segments of 30, total saturates at 255, dirs 1/5 alternate, turns=9, seg_count=10.
REQ-037 start; (5,5),(5,5),(7,5),(7,5),(7,2 last) -> dists 0,2,0,3; dirs 0,2,0,4; turns=1, seg_count=4, total=5.
REQ-038 start; (2,2),(4,4); rst_n low one cycle before next point -> all outputs 0, state IDLE; pt_valid ignored until next start.
REQ-039 start with pt_last on first point (9,9) -> no seg_valid, done pulses one cycle later, total=0, seg_count=0; start during RUN has no effect.

Source files
------------

// File: rtl/path_sequencer.sv
// Waypoint path sequencer: turns a stream of (x,y) waypoints into per-segment
// Manhattan distance/direction results plus running path statistics.

module path_dist_dir (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] c_i,
    input  logic [3:0] d_i,
    output logic [4:0] dist_o,
    output logic [2:0] dir_o
);
    logic [4:0] dx, dy, adx, ady;
    logic       x_pos, x_neg, y_pos, y_neg;

    assign dx     = {1'b0, c_i} - {1'b0, a_i};
    assign dy     = {1'b0, d_i} - {1'b0, b_i};
    assign adx    = dx[4] ? (5'd0 - dx) : dx;
    assign ady    = dy[4] ? (5'd0 - dy) : dy;
    assign dist_o = adx + ady;

    assign x_pos = c_i > a_i;
    assign x_neg = c_i < a_i;
    assign y_pos = d_i > b_i;
    assign y_neg = d_i < b_i;

    // +y is north, +x is east; a zero-length move reports N (0).
    always_comb begin
        case ({x_pos, x_neg, y_pos, y_neg})
            4'b1010: dir_o = 3'd1;
            4'b1000: dir_o = 3'd2;
            4'b1001: dir_o = 3'd3;
            4'b0001: dir_o = 3'd4;
            4'b0101: dir_o = 3'd5;
            4'b0100: dir_o = 3'd6;
            4'b0110: dir_o = 3'd7;
            default: dir_o = 3'd0;
        endcase
    end
endmodule

module path_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pt_valid,
    input  logic [3:0] pt_x,
    input  logic [3:0] pt_y,
    input  logic       pt_last,
    output logic       pt_ready,
    output logic       seg_valid,
    output logic [3:0] seg_dist,
    output logic       seg_wrap,
    output logic [2:0] seg_dir,
    output logic [7:0] total,
    output logic [3:0] seg_count,
    output logic [3:0] turns,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN} state_t;

    state_t     state_q, state_d;
    logic [3:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic       seg_valid_q, seg_valid_d, seg_wrap_q, seg_wrap_d;
    logic [3:0] seg_dist_q, seg_dist_d;
    logic [2:0] seg_dir_q, seg_dir_d, prev_dir_q, prev_dir_d;
    logic       prev_dir_vld_q, prev_dir_vld_d;
    logic [7:0] total_q, total_d;
    logic [3:0] seg_count_q, seg_count_d, turns_q, turns_d;
    logic       done_q, done_d;

    logic       accept;
    logic [4:0] dist_sum;
    logic [2:0] dir;
    logic [8:0] total_sum;

    path_dist_dir u_dist_dir (
        .a_i    (prev_x_q),
        .b_i    (prev_y_q),
        .c_i    (pt_x),
        .d_i    (pt_y),
        .dist_o (dist_sum),
        .dir_o  (dir)
    );

    assign accept    = pt_valid & pt_ready;
    assign total_sum = {1'b0, total_q} + {4'b0000, dist_sum};

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pt_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FIRST;
            end
            S_FIRST: begin
                pt_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_d = pt_last ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                pt_ready = 1'b1;
                busy     = 1'b1;
                if (accept && pt_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prev_x_d       = prev_x_q;
        prev_y_d       = prev_y_q;
        seg_valid_d    = 1'b0;
        seg_dist_d     = seg_dist_q;
        seg_wrap_d     = seg_wrap_q;
        seg_dir_d      = seg_dir_q;
        prev_dir_d     = prev_dir_q;
        prev_dir_vld_d = prev_dir_vld_q;
        total_d        = total_q;
        seg_count_d    = seg_count_q;
        turns_d        = turns_q;
        done_d         = 1'b0;

        if (state_q == S_IDLE && start) begin
            total_d        = 8'd0;
            seg_count_d    = 4'd0;
            turns_d        = 4'd0;
            prev_dir_vld_d = 1'b0;
        end

        if (accept) begin
            prev_x_d = pt_x;
            prev_y_d = pt_y;
            done_d   = pt_last;
            if (state_q == S_RUN) begin
                seg_valid_d = 1'b1;
                seg_dist_d  = dist_sum[3:0];
                seg_wrap_d  = dist_sum[4];
                seg_dir_d   = dir;
                total_d     = total_sum[8] ? 8'hFF : total_sum[7:0];
                seg_count_d = (seg_count_q == 4'hF) ? seg_count_q : seg_count_q + 4'd1;
                // Zero-length segments never affect turn tracking.
                if (dist_sum != 5'd0) begin
                    if (prev_dir_vld_q && dir != prev_dir_q && turns_q != 4'hF)
                        turns_d = turns_q + 4'd1;
                    prev_dir_d     = dir;
                    prev_dir_vld_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            prev_x_q       <= 4'd0;
            prev_y_q       <= 4'd0;
            seg_valid_q    <= 1'b0;
            seg_dist_q     <= 4'd0;
            seg_wrap_q     <= 1'b0;
            seg_dir_q      <= 3'd0;
            prev_dir_q     <= 3'd0;
            prev_dir_vld_q <= 1'b0;
            total_q        <= 8'd0;
            seg_count_q    <= 4'd0;
            turns_q        <= 4'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_x_q       <= prev_x_d;
            prev_y_q       <= prev_y_d;
            seg_valid_q    <= seg_valid_d;
            seg_dist_q     <= seg_dist_d;
            seg_wrap_q     <= seg_wrap_d;
            seg_dir_q      <= seg_dir_d;
            prev_dir_q     <= prev_dir_d;
            prev_dir_vld_q <= prev_dir_vld_d;
            total_q        <= total_d;
            seg_count_q    <= seg_count_d;
            turns_q        <= turns_d;
            done_q         <= done_d;
        end
    end

    assign seg_valid = seg_valid_q;
    assign seg_dist  = seg_dist_q;
    assign seg_wrap  = seg_wrap_q;
    assign seg_dir   = seg_dir_q;
    assign total     = total_q;
    assign seg_count = seg_count_q;
    assign turns     = turns_q;
    assign done      = done_q;
endmodule
